// File: rtl/router_rr_pkg.sv
// Shared constants, types and message field helpers for the round-robin XY router.
// The message destination sits in the top bits as {row, col}; everything below it is the payload.
package router_rr_pkg;
  localparam int MSG_WIDTH       = 32;
  localparam int CORDINATE_WIDTH = 4;
  localparam int FIFO_DEPTH      = 4;
  localparam int NUM_PORTS       = 5;

  localparam int PORT_SELF  = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_SOUTH = 2;
  localparam int PORT_EAST  = 3;
  localparam int PORT_WEST  = 4;

  localparam logic [2*CORDINATE_WIDTH-1:0] BCAST_ADDR = '1;

  typedef logic [CORDINATE_WIDTH-1:0]             coord_t;
  typedef logic [MSG_WIDTH-1:0]                   msg_t;
  typedef logic [MSG_WIDTH-2*CORDINATE_WIDTH-1:0] body_t;

  typedef enum logic {ST_IDLE, ST_BCAST} bc_state_e;

  function automatic coord_t rx_row(input msg_t m);
    return m[MSG_WIDTH-1 -: CORDINATE_WIDTH];
  endfunction

  function automatic coord_t rx_col(input msg_t m);
    return m[MSG_WIDTH-CORDINATE_WIDTH-1 -: CORDINATE_WIDTH];
  endfunction

  function automatic body_t msg_body(input msg_t m);
    return m[MSG_WIDTH-2*CORDINATE_WIDTH-1:0];
  endfunction

  function automatic msg_t make_msg(input coord_t row, input coord_t col, input body_t body);
    return {row, col, body};
  endfunction
endpackage

// File: rtl/router_rr_if.sv
// Per-port inbound/outbound handshake bundle of the router; lane k is bits [k*MSG_WIDTH +: MSG_WIDTH].
interface router_rr_if #(
  parameter int MSG_WIDTH = router_rr_pkg::MSG_WIDTH,
  parameter int NUM_PORTS = router_rr_pkg::NUM_PORTS
);
  logic [NUM_PORTS*MSG_WIDTH-1:0] in_value;
  logic [NUM_PORTS-1:0]           in_valid;
  logic [NUM_PORTS-1:0]           in_ready;
  logic [NUM_PORTS*MSG_WIDTH-1:0] out_value;
  logic [NUM_PORTS-1:0]           out_valid;
  logic [NUM_PORTS-1:0]           out_ready;

  modport slave (
    input  in_value, in_valid, out_ready,
    output in_ready, out_value, out_valid
  );

  modport master (
    output in_value, in_valid, out_ready,
    input  in_ready, out_value, out_valid
  );
endinterface

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO; writes to a full FIFO are dropped, reads of an empty FIFO ignored.
module fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1, moves the pointer only when advance is set.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand;
  int            c;

  // Scan from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    c         = 0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      c    = (int'(last_q) + k) % N;
      cand = IW'(c);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
    last_d = advance ? grant_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= IW'(N-1);
    else       last_q <= last_d;
  end
endmodule

// File: rtl/router_rr.sv
// Five-port XY mesh router: FWFT input FIFOs, round-robin grant, one register slot per output,
// and a broadcast FSM that fans a message out to the four neighbours with rewritten destinations.
module router_rr #(
  parameter int MSG_WIDTH       = router_rr_pkg::MSG_WIDTH,
  parameter int CORDINATE_WIDTH = router_rr_pkg::CORDINATE_WIDTH,
  parameter int FIFO_DEPTH      = router_rr_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CORDINATE_WIDTH-1:0] ROW_ID,
  input  logic [CORDINATE_WIDTH-1:0] COL_ID,
  router_rr_if.slave                 bus
);
  import router_rr_pkg::*;

  logic [NUM_PORTS-1:0]           fifo_full, fifo_empty, deq, req, grant, load, slot_free;
  logic [2:0]                     grant_idx, tgt;
  logic [MSG_WIDTH-1:0]           fifo_head  [NUM_PORTS];
  logic [MSG_WIDTH-1:0]           load_val   [NUM_PORTS];
  logic [MSG_WIDTH-1:0]           bcast_copy [1:NUM_PORTS-1];
  msg_t                           head;
  body_t                          body;
  coord_t                         dst_row, dst_col;
  logic                           head_bcast;
  bc_state_e                      state_q, state_d;
  logic [3:0]                     pending_q, pending_d, pend_now, pend_left;
  logic [2:0]                     src_q, src_d;
  logic [NUM_PORTS-1:0]           out_valid_q, out_valid_d;
  logic [NUM_PORTS*MSG_WIDTH-1:0] out_value_q, out_value_d;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    fifo_fwft #(.WIDTH(MSG_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.in_valid[i]),
      .wr_data (bus.in_value[i*MSG_WIDTH +: MSG_WIDTH]),
      .full    (fifo_full[i]),
      .rd_en   (deq[i]),
      .rd_data (fifo_head[i]),
      .empty   (fifo_empty[i])
    );
  end

  // While a broadcast is outstanding only its source may request, which locks the grant.
  assign req = (state_q == ST_BCAST) ? (NUM_PORTS'(1) << src_q) : ~fifo_empty;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .advance   (|deq),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign slot_free     = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = ~fifo_full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;

  always_comb begin
    head       = fifo_head[grant_idx];
    dst_row    = rx_row(head);
    dst_col    = rx_col(head);
    body       = msg_body(head);
    head_bcast = ({dst_row, dst_col} == BCAST_ADDR);
    if (dst_row == ROW_ID && dst_col == COL_ID) tgt = 3'(PORT_SELF);
    else if (dst_row < ROW_ID)                  tgt = 3'(PORT_NORTH);
    else if (dst_row > ROW_ID)                  tgt = 3'(PORT_SOUTH);
    else if (dst_col > COL_ID)                  tgt = 3'(PORT_EAST);
    else                                        tgt = 3'(PORT_WEST);
    bcast_copy[PORT_NORTH] = make_msg(ROW_ID - coord_t'(1), COL_ID, body);
    bcast_copy[PORT_SOUTH] = make_msg(ROW_ID + coord_t'(1), COL_ID, body);
    bcast_copy[PORT_EAST]  = make_msg(ROW_ID, COL_ID + coord_t'(1), body);
    bcast_copy[PORT_WEST]  = make_msg(ROW_ID, COL_ID - coord_t'(1), body);
  end

  // pending bit p-1 tracks neighbour port p (N,S,E,W); self never takes a broadcast copy.
  always_comb begin
    load      = '0;
    deq       = '0;
    state_d   = state_q;
    pending_d = pending_q;
    src_d     = src_q;
    pend_now  = (state_q == ST_BCAST) ? pending_q : 4'b1111;
    pend_left = pend_now & ~slot_free[NUM_PORTS-1:1];
    for (int p = 0; p < NUM_PORTS; p++) load_val[p] = head;
    if (|grant) begin
      if (state_q == ST_BCAST || head_bcast) begin
        for (int p = 1; p < NUM_PORTS; p++) begin
          if (pend_now[p-1] && slot_free[p]) begin
            load[p]     = 1'b1;
            load_val[p] = bcast_copy[p];
          end
        end
        if (pend_left == 4'b0000) begin
          deq[grant_idx] = 1'b1;
          state_d        = ST_IDLE;
          pending_d      = 4'b0000;
        end else begin
          state_d   = ST_BCAST;
          pending_d = pend_left;
          src_d     = grant_idx;
        end
      end else if (slot_free[tgt]) begin
        load[tgt]      = 1'b1;
        deq[grant_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    out_value_d = out_value_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_valid_d[p] = out_valid_q[p] & ~bus.out_ready[p];
      if (load[p]) begin
        out_valid_d[p]                             = 1'b1;
        out_value_d[p*MSG_WIDTH +: MSG_WIDTH] = load_val[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 4'b0000;
      src_q       <= '0;
      out_valid_q <= '0;
      out_value_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      src_q       <= src_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
    end
  end
endmodule

// File: tb/tb_router_rr.sv
// Directed bench for router_rr: unicast latency, round-robin order, broadcast fan-out with
// back-pressure, FIFO full/drop behaviour, coordinate wrap and reset during a broadcast.
module tb_router_rr;
  logic       clk;
  logic       reset;
  logic [3:0] row_id, col_id;
  int         n_checks;
  int         n_err;

  router_rr_if #(.MSG_WIDTH(32), .NUM_PORTS(5)) bus ();

  router_rr dut (
    .clk    (clk),
    .reset  (reset),
    .ROW_ID (row_id),
    .COL_ID (col_id),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] m(input logic [3:0] r, input logic [3:0] c, input logic [23:0] p);
    return {r, c, p};
  endfunction

  function automatic logic [31:0] lane(input int k);
    return bus.out_value[k*32 +: 32];
  endfunction

  task automatic put(input int k, input logic [31:0] v);
    bus.in_value[k*32 +: 32] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    reset         = 1'b1;
    row_id        = 4'd2;
    col_id        = 4'd3;
    bus.in_valid  = '0;
    bus.in_value  = '0;
    bus.out_ready = 5'b11111;
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 5'b00000);
    chk("rst_out_value", bus.out_value, '0);
    chk("rst_in_ready", bus.in_ready, 5'b11111);
    reset = 1'b0;

    // Self unicast: appears one cycle after the write lands.
    put(0, m(4'd2, 4'd3, 24'hABCDE));
    bus.in_valid = 5'b00001;
    step();
    bus.in_valid = '0;
    chk("self_landed", bus.out_valid, 5'b00000);
    step();
    chk("self_valid", bus.out_valid, 5'b00001);
    chk("self_value", lane(0), m(4'd2, 4'd3, 24'hABCDE));
    step();
    chk("self_drained", bus.out_valid, 5'b00000);

    // Round robin N,S,E all to (5,3) -> south output, pointer at self.
    put(1, m(4'd5, 4'd3, 24'h1));
    put(2, m(4'd5, 4'd3, 24'h2));
    put(3, m(4'd5, 4'd3, 24'h3));
    bus.in_valid = 5'b01110;
    step();
    bus.in_valid = '0;
    chk("rr_landed", bus.out_valid, 5'b00000);
    step();
    chk("rr_v1", bus.out_valid, 5'b00100);
    chk("rr_north", lane(2), m(4'd5, 4'd3, 24'h1));
    step();
    chk("rr_south", lane(2), m(4'd5, 4'd3, 24'h2));
    step();
    chk("rr_east", lane(2), m(4'd5, 4'd3, 24'h3));
    step();
    chk("rr_done", bus.out_valid, 5'b00000);

    // Broadcast from west with the east slot held by a stalled message.
    bus.out_ready = 5'b10111;
    put(1, m(4'd2, 4'd4, 24'h11));
    bus.in_valid = 5'b00010;
    step();
    put(4, m(4'hF, 4'hF, 24'h55));
    put(0, m(4'd2, 4'd3, 24'h77));
    bus.in_valid = 5'b10001;
    step();
    bus.in_valid = '0;
    chk("bc_east_busy", bus.out_valid, 5'b01000);
    chk("bc_east_old", lane(3), m(4'd2, 4'd4, 24'h11));
    step();
    chk("bc_fanout", bus.out_valid, 5'b11110);
    chk("bc_n", lane(1), m(4'd1, 4'd3, 24'h55));
    chk("bc_s", lane(2), m(4'd3, 4'd3, 24'h55));
    chk("bc_w", lane(4), m(4'd2, 4'd2, 24'h55));
    chk("bc_e_held", lane(3), m(4'd2, 4'd4, 24'h11));
    step();
    chk("bc_self_blocked1", bus.out_valid, 5'b01000);
    step();
    chk("bc_self_blocked2", bus.out_valid, 5'b01000);
    bus.out_ready = 5'b11111;
    step();
    chk("bc_e_valid", bus.out_valid, 5'b01000);
    chk("bc_e", lane(3), m(4'd2, 4'd4, 24'h55));
    step();
    chk("bc_self_after", bus.out_valid, 5'b00001);
    chk("bc_self_val", lane(0), m(4'd2, 4'd3, 24'h77));
    step();
    chk("bc_idle", bus.out_valid, 5'b00000);

    // North FIFO fills while the north slot is stalled; the 5th write is dropped.
    bus.out_ready = 5'b11101;
    put(0, m(4'd0, 4'd3, 24'h99));
    bus.in_valid = 5'b00001;
    step();
    put(1, m(4'd0, 4'd3, 24'h1));
    bus.in_valid = 5'b00010;
    step();
    chk("full_slot", bus.out_valid, 5'b00010);
    put(1, m(4'd0, 4'd3, 24'h2));
    step();
    put(1, m(4'd0, 4'd3, 24'h3));
    step();
    put(1, m(4'd0, 4'd3, 24'h4));
    step();
    chk("full_in_ready", bus.in_ready, 5'b11101);
    put(1, m(4'd0, 4'd3, 24'h5));
    step();
    bus.in_valid = '0;
    chk("full_in_ready2", bus.in_ready, 5'b11101);
    chk("full_hold_v", bus.out_valid, 5'b00010);
    chk("full_hold", lane(1), m(4'd0, 4'd3, 24'h99));
    bus.out_ready = 5'b11111;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("full_drain_v", bus.out_valid, 5'b00010);
      chk("full_drain", lane(1), m(4'd0, 4'd3, 24'(i)));
    end
    step();
    chk("full_empty", bus.out_valid, 5'b00000);
    chk("full_ready_back", bus.in_ready, 5'b11111);

    // Row 0 broadcast wraps north to row 15; reset lands mid-broadcast.
    row_id        = 4'd0;
    bus.out_ready = 5'b00000;
    put(0, m(4'hF, 4'hF, 24'hAA));
    bus.in_valid = 5'b00001;
    step();
    put(0, m(4'hF, 4'hF, 24'hBB));
    step();
    bus.in_valid = '0;
    chk("wrap_valid", bus.out_valid, 5'b11110);
    chk("wrap_n", lane(1), m(4'hF, 4'd3, 24'hAA));
    chk("wrap_s", lane(2), m(4'd1, 4'd3, 24'hAA));
    chk("wrap_e", lane(3), m(4'd0, 4'd4, 24'hAA));
    chk("wrap_w", lane(4), m(4'd0, 4'd2, 24'hAA));
    step();
    chk("stall_valid", bus.out_valid, 5'b11110);
    chk("stall_n", lane(1), m(4'hF, 4'd3, 24'hAA));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_bc_valid", bus.out_valid, 5'b00000);
    chk("rst_bc_value", bus.out_value, '0);
    chk("rst_bc_ready", bus.in_ready, 5'b11111);
    bus.out_ready = 5'b11111;
    step();
    chk("rst_no_resid1", bus.out_valid, 5'b00000);
    step();
    chk("rst_no_resid2", bus.out_valid, 5'b00000);
    put(2, m(4'd0, 4'd3, 24'hCC));
    bus.in_valid = 5'b00100;
    step();
    bus.in_valid = '0;
    step();
    chk("post_rst_idle", bus.out_valid, 5'b00001);
    chk("post_rst_val", lane(0), m(4'd0, 4'd3, 24'hCC));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
